// File: rtl/audio_dds_source.sv
// audio_dds_source: one DDS sine sample per LRCK frame for the codec serializer.
// Phase accumulator -> quarter-wave ROM -> quadrant sign -> arithmetic shift.
module audio_dds_source #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned LUT_ADDR    = 6
) (
  input  logic                   iCLK_18_4,
  input  logic                   iRST_N,
  input  logic                   iLRCK,
  input  logic                   iEnable,
  input  logic [PHASE_WIDTH-1:0] iTuning,
  input  logic [3:0]             iAmp,
  output logic [DATA_WIDTH-1:0]  oSample,
  output logic                   oSample_Valid,
  output logic                   oBusy,
  output logic                   oOverrun
);

  localparam int unsigned LUT_DEPTH = 1 << LUT_ADDR;
  localparam int unsigned AMP_W     = 4;
  localparam int unsigned FRAC      = 30;
  localparam longint      PI_Q30    = 64'sd3373259426;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_SIGN,
    S_SCALE,
    S_OUT
  } state_e;

  // ROM entry k = round(FS * sin(pi/2 * (k+0.5)/DEPTH)), evaluated at elaboration
  // with a Q30 Taylor series so the table follows the parameters.
  function automatic logic [DATA_WIDTH-1:0] lut_val(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint full_scale;
    longint v;
    full_scale = (longint'(1) <<< (DATA_WIDTH - 1)) - 64'sd1;
    x    = (PI_Q30 * longint'(2 * k + 1)) / longint'(4 * LUT_DEPTH);
    x2   = (x * x) >>> FRAC;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = ((term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) sum = sum - term;
      else              sum = sum + term;
    end
    v = (sum * full_scale + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    return DATA_WIDTH'(v);
  endfunction

  logic [DATA_WIDTH-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [DATA_WIDTH-1:0] ENTRY = lut_val(k);
    assign lut_rom[k] = ENTRY;
  end

  state_e                 state_q,   state_d;
  logic                   lrck_s1_q, lrck_s1_d;
  logic                   lrck_s2_q, lrck_s2_d;
  logic                   lrck_h_q,  lrck_h_d;
  logic [PHASE_WIDTH-1:0] phase_q,   phase_d;
  logic [PHASE_WIDTH-1:0] tuning_q,  tuning_d;
  logic [AMP_W-1:0]       amp_q,     amp_d;
  logic                   en_q,      en_d;
  logic                   neg_q,     neg_d;
  logic [LUT_ADDR-1:0]    addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]  rom_q,     rom_d;
  logic [DATA_WIDTH-1:0]  signval_q, signval_d;
  logic [DATA_WIDTH-1:0]  scaled_q,  scaled_d;
  logic [DATA_WIDTH-1:0]  sample_q,  sample_d;
  logic                   valid_q,   valid_d;
  logic                   busy_q,    busy_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_edge_c;
  logic [LUT_ADDR-1:0]    raw_addr_c;

  // Synchronized LRCK falling edge marks a new frame.
  assign frame_edge_c = lrck_h_q & ~lrck_s2_q;
  assign raw_addr_c   = phase_q[PHASE_WIDTH-3 -: LUT_ADDR];

  // Next-state and datapath: one pipeline step per FSM state.
  always_comb begin
    lrck_s1_d = iLRCK;
    lrck_s2_d = lrck_s1_q;
    lrck_h_d  = lrck_s2_q;
    state_d   = state_q;
    phase_d   = phase_q;
    tuning_d  = tuning_q;
    amp_d     = amp_q;
    en_d      = en_q;
    neg_d     = neg_q;
    addr_d    = addr_q;
    rom_d     = rom_q;
    signval_d = signval_q;
    scaled_d  = scaled_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    if (frame_edge_c && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_edge_c) begin
          state_d  = S_ADDR;
          tuning_d = iTuning;
          amp_d    = iAmp;
          en_d     = iEnable;
        end
      end
      S_ADDR: begin
        // Odd quadrants walk the quarter wave backwards; upper half is negative.
        neg_d   = phase_q[PHASE_WIDTH-1];
        addr_d  = phase_q[PHASE_WIDTH-2] ? ~raw_addr_c : raw_addr_c;
        state_d = S_READ;
      end
      S_READ: begin
        rom_d   = lut_rom[addr_q];
        state_d = S_SIGN;
      end
      S_SIGN: begin
        signval_d = neg_q ? -rom_q : rom_q;
        state_d   = S_SCALE;
      end
      S_SCALE: begin
        scaled_d = $signed(signval_q) >>> amp_q;
        state_d  = S_OUT;
      end
      S_OUT: begin
        valid_d = 1'b1;
        if (en_q) begin
          sample_d = scaled_q;
          phase_d  = phase_q + tuning_q;
        end else begin
          sample_d = '0;
          phase_d  = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and pipeline registers; synchronizer resets to LRCK-high.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      lrck_s1_q <= 1'b1;
      lrck_s2_q <= 1'b1;
      lrck_h_q  <= 1'b1;
      phase_q   <= '0;
      tuning_q  <= '0;
      amp_q     <= '0;
      en_q      <= 1'b0;
      neg_q     <= 1'b0;
      addr_q    <= '0;
      rom_q     <= '0;
      signval_q <= '0;
      scaled_q  <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lrck_s1_q <= lrck_s1_d;
      lrck_s2_q <= lrck_s2_d;
      lrck_h_q  <= lrck_h_d;
      phase_q   <= phase_d;
      tuning_q  <= tuning_d;
      amp_q     <= amp_d;
      en_q      <= en_d;
      neg_q     <= neg_d;
      addr_q    <= addr_d;
      rom_q     <= rom_d;
      signval_q <= signval_d;
      scaled_q  <= scaled_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign oSample       = sample_q;
  assign oSample_Valid = valid_q;
  assign oBusy         = busy_q;
  assign oOverrun      = overrun_q;

endmodule

// File: tb/tb_audio_dds_source.sv
// Bench for audio_dds_source: directed anchors plus randomized frames against a sine model.
module tb_audio_dds_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lrck;
  logic        en;
  logic [23:0] tuning;
  logic [3:0]  amp;
  logic [15:0] sample;
  logic        valid;
  logic        busy;
  logic        overrun;

  int vectors    = 0;
  int miscompares = 0;

  int          lut_model [64];
  logic [23:0] m_phase;

  localparam logic [9:0] VALID_PAT = 10'b0010000000;
  localparam logic [9:0] BUSY_PAT  = 10'b0001111100;

  audio_dds_source #(
    .DATA_WIDTH (16),
    .PHASE_WIDTH(24),
    .LUT_ADDR   (6)
  ) dut (
    .iCLK_18_4    (clk),
    .iRST_N       (rst_n),
    .iLRCK        (lrck),
    .iEnable      (en),
    .iTuning      (tuning),
    .iAmp         (amp),
    .oSample      (sample),
    .oSample_Valid(valid),
    .oBusy        (busy),
    .oOverrun     (overrun)
  );

  always #5 clk = ~clk;

  // Sine of the bucket centre, quantized to full scale.
  function automatic int sine_entry(input int k);
    real ang;
    ang = 3.14159265358979323846 * real'(2 * k + 1) / 256.0;
    return $rtoi(32767.0 * $sin(ang) + 0.5);
  endfunction

  // Waveform value at a given phase with a given attenuation.
  function automatic logic [15:0] model_sample(input logic [23:0] ph, input int sh);
    int q;
    int a;
    int mag;
    int v;
    q   = int'(ph >> 22);
    a   = int'((ph >> 16) & 24'h3F);
    mag = ((q % 2) == 1) ? lut_model[63 - a] : lut_model[a];
    v   = (q >= 2) ? -mag : mag;
    v   = v >>> sh;
    return v[15:0];
  endfunction

  // Expected sample for the next frame; advances the model phase.
  function automatic logic [15:0] model_step(input logic [23:0] tun, input int sh, input logic ena);
    logic [15:0] r;
    if (!ena) begin
      r       = 16'h0000;
      m_phase = 24'h000000;
    end else begin
      r       = model_sample(m_phase, sh);
      m_phase = m_phase + tun;
    end
    return r;
  endfunction

  // One LRCK fall, then 10 clocks of valid/busy history and the emitted sample.
  task automatic run_frame(input logic [23:0] tun, input logic [3:0] sh, input logic ena,
                           input bit scramble, output logic [15:0] smp,
                           output logic [9:0] vhist, output logic [9:0] bhist);
    tuning = tun;
    amp    = sh;
    en     = ena;
    smp    = 16'hxxxx;
    vhist  = '0;
    bhist  = '0;
    @(posedge clk);
    #1 lrck = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      vhist[c-1] = valid;
      bhist[c-1] = busy;
      if (valid) smp = sample;
      if (scramble && c == 4) begin
        tuning = 24'($urandom);
        amp    = 4'($urandom);
        en     = 1'($urandom);
      end
    end
    lrck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    lrck   = 1'b1;
    en     = 1'b1;
    tuning = 24'h400000;
    amp    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lrck = ~lrck;
      vectors++;
      if ({sample, valid, busy, overrun} !== 19'h0) begin
        miscompares++;
        $display("FAIL reset[%0d]: sample=%h valid=%b busy=%b overrun=%b, required all zero",
                 i, sample, valid, busy, overrun);
      end
    end
    lrck = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_phase = 24'h0;
  endtask

  task automatic test_quadrant_walk();
    logic [15:0] smp;
    logic [15:0] exp;
    logic [9:0]  vh;
    logic [9:0]  bh;
    logic [15:0] anchors [4];
    anchors = '{16'd402, 16'd32765, 16'hFE6E, 16'h8003};
    for (int i = 0; i < 4; i++) begin
      exp = model_step(24'h400000, 0, 1'b1);
      run_frame(24'h400000, 4'd0, 1'b1, 1'b0, smp, vh, bh);
      vectors++;
      if (smp !== anchors[i]) begin
        miscompares++;
        $display("FAIL quadrant_anchor[%0d]: got %h required %h", i, smp, anchors[i]);
      end
      vectors++;
      if (smp !== exp) begin
        miscompares++;
        $display("FAIL quadrant_model[%0d]: got %h required %h", i, smp, exp);
      end
      vectors++;
      if (vh !== VALID_PAT) begin
        miscompares++;
        $display("FAIL quadrant_valid_timing[%0d]: got %b required %b", i, vh, VALID_PAT);
      end
      vectors++;
      if (bh !== BUSY_PAT) begin
        miscompares++;
        $display("FAIL quadrant_busy_timing[%0d]: got %b required %b", i, bh, BUSY_PAT);
      end
    end
  endtask

  task automatic test_attenuation();
    logic [15:0] smp;
    logic [15:0] exp;
    logic [9:0]  vh;
    logic [9:0]  bh;
    for (int i = 0; i < 4; i++) begin
      exp = model_step(24'h400000, 2, 1'b1);
      run_frame(24'h400000, 4'd2, 1'b1, 1'b1, smp, vh, bh);
      vectors++;
      if (smp !== exp) begin
        miscompares++;
        $display("FAIL atten_model[%0d]: got %h required %h", i, smp, exp);
      end
      if (i == 1) begin
        vectors++;
        if (smp !== 16'h1FFF) begin
          miscompares++;
          $display("FAIL atten_sample2: got %h required 1fff", smp);
        end
      end
      if (i == 3) begin
        vectors++;
        if (smp !== 16'hE000) begin
          miscompares++;
          $display("FAIL atten_sample4: got %h required e000", smp);
        end
      end
    end
  endtask

  task automatic test_wrap_disable();
    logic [15:0] smp;
    logic [15:0] exp;
    logic [9:0]  vh;
    logic [9:0]  bh;
    logic [15:0] want [4];
    logic [23:0] tun  [4];
    logic        ena  [4];
    want = '{16'd402, 16'hFE6E, 16'h0000, 16'd402};
    tun  = '{24'hFFFFFF, 24'hFFFFFF, 24'h123456, 24'h000100};
    ena  = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp = model_step(tun[i], 0, ena[i]);
      run_frame(tun[i], 4'd0, ena[i], 1'b0, smp, vh, bh);
      vectors++;
      if (smp !== want[i] || smp !== exp) begin
        miscompares++;
        $display("FAIL wrap_disable[%0d]: got %h required %h (model %h)", i, smp, want[i], exp);
      end
      vectors++;
      if (vh !== VALID_PAT) begin
        miscompares++;
        $display("FAIL wrap_disable_valid[%0d]: got %b required %b", i, vh, VALID_PAT);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] smp;
    logic [15:0] exp;
    logic [9:0]  vh;
    logic [9:0]  bh;
    logic [23:0] tun;
    logic [3:0]  sh;
    logic        ena;
    for (int i = 0; i < 40; i++) begin
      tun = 24'($urandom);
      sh  = (($urandom_range(0, 3)) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      ena = ($urandom_range(0, 7) != 0);
      exp = model_step(tun, int'(sh), ena);
      run_frame(tun, sh, ena, 1'b1, smp, vh, bh);
      vectors++;
      if (smp !== exp) begin
        miscompares++;
        $display("FAIL random_sample[%0d]: got %h required %h (tun=%h amp=%0d en=%b)",
                 i, smp, exp, tun, sh, ena);
      end
      vectors++;
      if (sample !== exp) begin
        miscompares++;
        $display("FAIL random_hold[%0d]: got %h required %h", i, sample, exp);
      end
      vectors++;
      if (vh !== VALID_PAT || bh !== BUSY_PAT) begin
        miscompares++;
        $display("FAIL random_timing[%0d]: valid %b busy %b required %b %b",
                 i, vh, bh, VALID_PAT, BUSY_PAT);
      end
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL random_no_overrun: got %b required 0", overrun);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] smp;
    logic [15:0] exp;
    logic [9:0]  vh;
    logic [9:0]  bh;
    int          pulses;
    tuning = 24'h0A0000;
    amp    = 4'd0;
    en     = 1'b1;
    exp    = model_step(24'h0A0000, 0, 1'b1);
    pulses = 0;
    smp    = 16'hxxxx;
    @(posedge clk);
    #1 lrck = 1'b0;
    @(posedge clk);
    #1 lrck = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 lrck = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        smp = sample;
      end
    end
    lrck = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL overrun_pulses: got %0d required 1", pulses);
    end
    vectors++;
    if (smp !== exp) begin
      miscompares++;
      $display("FAIL overrun_sample: got %h required %h", smp, exp);
    end
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_flag: got %b required 1", overrun);
    end
    exp = model_step(24'h0A0000, 0, 1'b1);
    run_frame(24'h0A0000, 4'd0, 1'b1, 1'b0, smp, vh, bh);
    vectors++;
    if (smp !== exp) begin
      miscompares++;
      $display("FAIL overrun_next_sample: got %h required %h", smp, exp);
    end
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %b required 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] smp;
    logic [15:0] exp;
    logic [9:0]  vh;
    logic [9:0]  bh;
    int          pulses;
    tuning = 24'h123456;
    amp    = 4'd0;
    en     = 1'b1;
    @(posedge clk);
    #1 lrck = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({sample, valid, busy, overrun} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: sample=%h valid=%b busy=%b overrun=%b, required all zero",
               sample, valid, busy, overrun);
    end
    repeat (3) @(negedge clk);
    lrck = 1'b1;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    vectors++;
    if (pulses !== 0 || sample !== 16'h0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: pulses=%0d sample=%h overrun=%b, required 0 0000 0",
               pulses, sample, overrun);
    end
    m_phase = 24'h0;
    exp = model_step(24'h2468AC, 0, 1'b1);
    run_frame(24'h2468AC, 4'd0, 1'b1, 1'b0, smp, vh, bh);
    vectors++;
    if (smp !== 16'd402 || smp !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_first: got %h required 0192 (model %h)", smp, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 64; k++) lut_model[k] = sine_entry(k);
    m_phase = 24'h0;
    test_reset();
    test_quadrant_walk();
    test_attenuation();
    test_wrap_disable();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/audio_dds_source.md
# audio_dds_source

Direct-digital-synthesis sample source that sits immediately upstream of the audio codec serializer. Once per audio frame it produces one 16-bit two's-complement sine sample, synchronized to the serializer's LRCK. It replaces the fixed per-frame sine ROM walk with a programmable phase accumulator, a quarter-wave LUT and an amplitude shifter. The serializer latches `oSample` while `oSample_Valid` is high.

## Interface
- `DATA_WIDTH`, 16: sample width, two's complement.
- `PHASE_WIDTH`, 24: phase accumulator width.
- `LUT_ADDR`, 6: quarter-wave LUT address width (64 entries).
- `iCLK_18_4` input 1: system clock, 18.432 MHz.
- `iRST_N` input 1: reset; asynchronous, active-low.
- `iLRCK` input 1: LRCK from the serializer; asynchronous to this block's logic and synchronized internally.
- `iEnable` input 1: tone enable.
- `iTuning` input PHASE_WIDTH: phase increment per sample.
- `iAmp` input 4: attenuation, expressed as an arithmetic right shift of 0–15.
- `oSample` output DATA_WIDTH: current sample; held between updates.
- `oSample_Valid` output 1: one-clock pulse when `oSample` updates.
- `oBusy` output 1: high whenever the FSM is not in IDLE.
- `oOverrun` output 1: sticky flag for a frame edge dropped while busy; cleared only by reset.

## Operation
- `iLRCK` passes through a 2-flop synchronizer plus a third history flop. A frame edge is a synchronized 1→0 transition.
- Phase accumulator `phase[23:0]` resets to 0.
  - Bits [23:22] are the quadrant `q`.
  - Bits [21:16] are the LUT address `a`.
  - Bits [15:0] are ignored (truncation, no interpolation).
- LUT entry k = round(32767·sin(π/2·(k+0.5)/64)), k = 0..63. Anchor values: lut[0]=402, lut[63]=32765. The LUT is a registered ROM.
- Quadrant mapping:
  - q0: +lut[a]
  - q1: +lut[63−a]
  - q2: −lut[a]
  - q3: −lut[63−a]
  - Negation is 16-bit two's complement.
- Scaling is an arithmetic (sign-preserving) right shift of the signed value by `iAmp`.
- FSM states: IDLE, ADDR, READ, SIGN, SCALE, OUT.
  - IDLE→ADDR on a frame edge. At that edge, capture `iTuning`, `iAmp` and `iEnable`; later input changes do not affect the sample in flight.
  - ADDR: compute `q` and the mirrored address from the current phase.
  - READ: ROM output registers.
  - SIGN: apply the quadrant negation.
  - SCALE: apply the shift.
  - OUT: register `oSample`, pulse `oSample_Valid`, set phase ← (phase + captured tuning) mod 2^24, then return to IDLE.
- If the captured `iEnable` = 0:
  - OUT loads `oSample` = 0 and sets phase ← 0.
  - `oSample_Valid` still pulses.
- A frame edge detected in any state other than IDLE is dropped and sets `oOverrun`. The in-flight sample completes normally.
- The sample emitted for frame n uses the phase value accumulated before frame n. The first sample after reset uses phase 0.
- Phase wrap is natural modulo 2^24. `iTuning` = 0xFFFFFF therefore decrements the phase by 1 per frame.

## Timing
- Reset values: `oSample` = 0, `oSample_Valid` = 0, `oBusy` = 0, `oOverrun` = 0, phase = 0, FSM = IDLE, synchronizer flops = 1.
- A frame edge is detected 3 clocks after the `iLRCK` fall (2 synchronizer clocks plus 1 history clock, ±1 for asynchronous capture).
- Latency is fixed. The edge-detect clock is cycle 0:
  - ADDR at cycle 1, READ at 2, SIGN at 3, SCALE at 4, OUT at 5.
  - `oSample` and `oSample_Valid` change at the clock ending OUT, so `oSample_Valid` is high during cycle 6.
  - `oBusy` is high for cycles 1–5.
- At 48 kHz there are 384 clocks per frame, so the 6-clock pipeline never overruns in normal operation.
- `oSample` stays stable for at least 378 clocks around the serializer's next load.
- Reset asserted mid-operation returns every register to its reset value immediately. The sample in flight is discarded and no valid pulse occurs.

## Test plan
- **Reset:** assert `iRST_N`=0 for 10 clocks, toggling `iLRCK` → `oSample`=0x0000, `oSample_Valid`=0, `oBusy`=0, `oOverrun`=0 throughout.
- **Quadrant walk:** `iTuning`=0x400000, `iAmp`=0, `iEnable`=1, 4 frames → samples 402, 32765, 0xFE6E (−402), 0x8003 (−32765). Each valid pulse comes exactly 6 clocks after edge detect.
- **Attenuation:** same tuning, `iAmp`=2 → sample 2 = 8191 (0x1FFF), sample 4 = 0xE000 (−8192).
- **Wrap and disable:** `iTuning`=0xFFFFFF → second sample uses phase 0xFFFFFF (q3, a=63) = −lut[0] = 0xFE6E. Then `iEnable`=0 for one frame → `oSample`=0 with a valid pulse, and the next enabled sample = 402.
- **Overrun:** two `iLRCK` falls 3 clocks apart → one valid pulse, `oOverrun`=1, and `oOverrun` stays 1 until reset.
- **Reset mid-pipeline:** assert reset at cycle 3 after an edge → no valid pulse, `oSample`=0. The first post-reset sample = 402 (phase 0).
